// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the ID/EX pipeline register and its hazard logic.
// The stall performance counter is built only when STALL_PERF_CNT_EN is defined.
package pipeline_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_AW_DEF  = 5;
  localparam int ALUOP_W_DEF = 4;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    RUN   = 1'b0,
    HOLD1 = 1'b1
  } hz_state_e;

  // Number of stall cycles a hazard requires.
  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational hazard classifier: how many stall cycles the instruction in ID needs
// before its operands can be delivered by forwarding.
module id_hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              en_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_branch_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic              idex_mem_read_i,
  input  logic              idex_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_mem_read_i,
  output logic [1:0]        need_o
);

  localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

  function automatic logic src_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
    return (rd != RZ) && ((rd == rs) || (rd == rt));
  endfunction

  logic idex_hit;
  logic exmem_hit;

  assign idex_hit  = src_match(idex_rd_i, id_rs_i, id_rt_i);
  assign exmem_hit = src_match(exmem_rd_i, id_rs_i, id_rt_i);

  // A branch resolves in ID, so a load feeding it must also clear MEM: two bubbles.
  always_comb begin
    need_o = NEED_NONE;
    if (en_i) begin
      if (idex_mem_read_i && idex_hit) begin
        need_o = id_branch_i ? NEED_TWO : NEED_ONE;
      end else if (id_branch_i && idex_reg_write_i && idex_hit) begin
        need_o = NEED_ONE;
      end else if (id_branch_i && exmem_mem_read_i && exmem_hit) begin
        need_o = NEED_ONE;
      end
    end
  end

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / branch-operand stall generation.
// Define STALL_PERF_CNT_EN to build the saturating stall-cycle counter.
module id_ex_hazard_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_branch,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]  id_read_data1,
  input  logic [DATA_W-1:0]  id_read_data2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [REG_AW-1:0]  ex_mem_rd,
  input  logic               ex_mem_mem_read,
  input  logic               ex_flush,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               stall,
  output logic               ID_EX_valid,
  output logic               ID_EX_reg_write,
  output logic               ID_EX_mem_read,
  output logic               ID_EX_mem_write,
  output logic               ID_EX_mem_to_reg,
  output logic               ID_EX_alu_src,
  output logic [REG_AW-1:0]  ID_EX_rs,
  output logic [REG_AW-1:0]  ID_EX_rt,
  output logic [REG_AW-1:0]  ID_EX_rd,
  output logic [ALUOP_W-1:0] ID_EX_alu_op,
  output logic [DATA_W-1:0]  ID_EX_read_data1,
  output logic [DATA_W-1:0]  ID_EX_read_data2,
  output logic [DATA_W-1:0]  ID_EX_imm,
  output logic [31:0]        stall_count
);

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               alu_src;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [ALUOP_W-1:0] alu_op;
    logic [DATA_W-1:0]  rd1;
    logic [DATA_W-1:0]  rd2;
    logic [DATA_W-1:0]  imm;
  } idex_t;

  hz_state_e  state_q, state_d;
  idex_t      idex_q, idex_d;
  logic [1:0] need;

  id_hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .en_i             ((state_q == RUN) && id_valid && !ex_flush),
    .id_rs_i          (id_rs),
    .id_rt_i          (id_rt),
    .id_branch_i      (id_branch),
    .idex_rd_i        (idex_q.rd),
    .idex_mem_read_i  (idex_q.mem_read),
    .idex_reg_write_i (idex_q.reg_write),
    .exmem_rd_i       (ex_mem_rd),
    .exmem_mem_read_i (ex_mem_mem_read),
    .need_o           (need)
  );

  // A redirect overrides any pending stall: the waiting instruction is dead anyway.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    if (ex_flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          stall   = (need != NEED_NONE);
          state_d = (need == NEED_TWO) ? HOLD1 : RUN;
        end
        HOLD1: begin
          stall   = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  always_comb begin
    idex_d = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
               mem_write: id_mem_write, mem_to_reg: id_mem_to_reg, alu_src: id_alu_src,
               rs: id_rs, rt: id_rt, rd: id_rd, alu_op: id_alu_op,
               rd1: id_read_data1, rd2: id_read_data2, imm: id_imm};
    if (ex_flush || stall) begin
      idex_d = '0;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  assign ID_EX_valid      = idex_q.valid;
  assign ID_EX_reg_write  = idex_q.reg_write;
  assign ID_EX_mem_read   = idex_q.mem_read;
  assign ID_EX_mem_write  = idex_q.mem_write;
  assign ID_EX_mem_to_reg = idex_q.mem_to_reg;
  assign ID_EX_alu_src    = idex_q.alu_src;
  assign ID_EX_rs         = idex_q.rs;
  assign ID_EX_rt         = idex_q.rt;
  assign ID_EX_rd         = idex_q.rd;
  assign ID_EX_alu_op     = idex_q.alu_op;
  assign ID_EX_read_data1 = idex_q.rd1;
  assign ID_EX_read_data2 = idex_q.rd2;
  assign ID_EX_imm        = idex_q.imm;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (stall) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed + randomized bench for id_ex_hazard_stage against a behavioural model.
// Honours STALL_PERF_CNT_EN when computing the expected stall_count.
module tb_id_ex_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [3:0]  id_alu_op;
  logic [31:0] id_read_data1, id_read_data2, id_imm;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_mem_read;
  logic        ex_flush;
  logic        pc_write, if_id_write, stall;
  logic        ID_EX_valid, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write;
  logic        ID_EX_mem_to_reg, ID_EX_alu_src;
  logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_rd;
  logic [3:0]  ID_EX_alu_op;
  logic [31:0] ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_hazard_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
    .id_imm(id_imm), .ex_mem_rd(ex_mem_rd), .ex_mem_mem_read(ex_mem_mem_read),
    .ex_flush(ex_flush), .pc_write(pc_write), .if_id_write(if_id_write), .stall(stall),
    .ID_EX_valid(ID_EX_valid), .ID_EX_reg_write(ID_EX_reg_write),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
    .ID_EX_mem_to_reg(ID_EX_mem_to_reg), .ID_EX_alu_src(ID_EX_alu_src),
    .ID_EX_rs(ID_EX_rs), .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
    .ID_EX_alu_op(ID_EX_alu_op), .ID_EX_read_data1(ID_EX_read_data1),
    .ID_EX_read_data2(ID_EX_read_data2), .ID_EX_imm(ID_EX_imm),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [4:0] rs, rt, rd;
    logic [3:0] alu_op;
    logic [31:0] d1, d2, imm;
  } idex_t;

  idex_t  m = '0;
  logic   m_hold = 1'b0;   // one more forced stall cycle is owed
  longint m_cnt = 0;
  logic   m_chk = 1'b0;

  function automatic bit hit(input logic [4:0] r);
    return (r != 5'd0) && (r == id_rs || r == id_rt);
  endfunction

  function automatic int need_m();
    int n = 0;
    if (!id_valid || ex_flush) return 0;
    if (m.mem_read && hit(m.rd)) n = id_branch ? 2 : 1;
    if (id_branch && m.reg_write && !m.mem_read && hit(m.rd) && n < 1) n = 1;
    if (id_branch && ex_mem_mem_read && hit(ex_mem_rd) && n < 1) n = 1;
    return n;
  endfunction

  function automatic logic exp_stall();
    if (ex_flush) return 1'b0;
    if (m_hold) return 1'b1;
    return need_m() > 0;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef STALL_PERF_CNT_EN
    return 32'(m_cnt);
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m      <= '0;
      m_hold <= 1'b0;
      m_cnt  <= 0;
      m_chk  <= 1'b1;
    end else begin
      if (exp_stall() && m_cnt < 64'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      m_hold <= !ex_flush && !m_hold && (need_m() == 2);
      if (ex_flush || exp_stall()) m <= '0;
      else m <= '{id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
                  id_rs, id_rt, id_rd, id_alu_op, id_read_data1, id_read_data2, id_imm};
    end
  end

  always @(negedge clk) begin
    if (m_chk) begin
      chk("stall", stall, exp_stall());
      chk("pc_write", pc_write, !exp_stall());
      chk("if_id_write", if_id_write, !exp_stall());
      chk("ctrl", {ID_EX_valid, ID_EX_reg_write, ID_EX_mem_read, ID_EX_mem_write,
                   ID_EX_mem_to_reg, ID_EX_alu_src},
                  {m.valid, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg, m.alu_src});
      chk("regs", {ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_alu_op}, {m.rs, m.rt, m.rd, m.alu_op});
      chk("data", {ID_EX_read_data1, ID_EX_read_data2, ID_EX_imm}, {m.d1, m.d2, m.imm});
      chk("stall_count", stall_count, exp_cnt());
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic br, input logic rw, input logic mr,
                        input int rs, input int rt, input int rd);
    id_valid      = v;
    id_branch     = br;
    id_reg_write  = rw;
    id_mem_read   = mr;
    id_mem_to_reg = mr;
    id_alu_src    = mr;
    id_mem_write  = 1'b0;
    id_rs         = 5'(rs);
    id_rt         = 5'(rt);
    id_rd         = 5'(rd);
    id_alu_op     = 4'(rs + rd);
    id_read_data1 = $urandom;
    id_read_data2 = $urandom;
    id_imm        = $urandom;
  endtask

  initial begin
    reset = 1'b1;
    ex_flush = 1'b0;
    ex_mem_rd = '0;
    ex_mem_mem_read = 1'b0;
    set_id(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_valid", ID_EX_valid, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pc_write", pc_write, 1'b1);
    chk("rst_count", stall_count, 32'd0);

    // load-use: lw r8 then add using r8
    set_id(1, 0, 1, 1, 1, 8, 8);
    tick();
    set_id(1, 0, 1, 0, 8, 2, 3);
    #1 chk("lu_stall", stall, 1'b1);
    tick();
    chk("lu_bubble", ID_EX_valid, 1'b0);
    chk("lu_release", stall, 1'b0);
    tick();
    chk("lu_add_rs", ID_EX_rs, 5'd8);
    chk("lu_add_valid", ID_EX_valid, 1'b1);

    // ALU result feeding branch in ID
    set_id(1, 0, 1, 0, 4, 5, 9);
    tick();
    set_id(1, 1, 0, 0, 9, 6, 0);
    #1 chk("ba_stall", stall, 1'b1);
    tick();
    chk("ba_release", stall, 1'b0);
    tick();
    chk("ba_beq_rs", ID_EX_rs, 5'd9);

    // load feeding branch: two stall cycles
    set_id(1, 0, 1, 1, 1, 10, 10);
    tick();
    set_id(1, 1, 0, 0, 11, 10, 0);
    #1 chk("bl_stall1", stall, 1'b1);
    tick();
    ex_mem_rd = 5'd10;
    ex_mem_mem_read = 1'b1;
    #1 chk("bl_stall2", stall, 1'b1);
    chk("bl_bubble1", ID_EX_valid, 1'b0);
    tick();
    ex_mem_rd = '0;
    ex_mem_mem_read = 1'b0;
    #1 chk("bl_release", stall, 1'b0);
    tick();
    chk("bl_beq_rt", ID_EX_rt, 5'd10);
    chk("bl_beq_valid", ID_EX_valid, 1'b1);

    // register zero never hazards
    set_id(1, 0, 1, 1, 0, 0, 0);
    tick();
    set_id(1, 0, 1, 0, 0, 0, 5);
    #1 chk("r0_stall", stall, 1'b0);
    tick();
    chk("r0_captured", ID_EX_valid, 1'b1);

    // flush during the second stall cycle
    set_id(1, 0, 1, 1, 1, 10, 10);
    tick();
    set_id(1, 1, 0, 0, 11, 10, 0);
    tick();
    ex_flush = 1'b1;
    #1 chk("fl_stall", stall, 1'b0);
    chk("fl_pc_write", pc_write, 1'b1);
    tick();
    ex_flush = 1'b0;
    chk("fl_bubble", ID_EX_valid, 1'b0);
    set_id(1, 1, 0, 0, 11, 10, 0);
    #1 chk("fl_run", stall, 1'b0);
    tick();

    // reset during the second stall cycle
    set_id(1, 0, 1, 1, 1, 10, 10);
    tick();
    set_id(1, 1, 0, 0, 11, 10, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("rs_valid", ID_EX_valid, 1'b0);
    chk("rs_rt", ID_EX_rt, 5'd0);
    chk("rs_stall", stall, 1'b0);
    chk("rs_pc_write", pc_write, 1'b1);
    chk("rs_count", stall_count, 32'd0);

    // mixed traffic with a narrow register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      tick();
      ex_flush        = ($urandom_range(0, 15) == 0);
      ex_mem_mem_read = $urandom_range(0, 1);
      ex_mem_rd       = 5'($urandom_range(0, 3));
      set_id($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
    end
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
